// File: rtl/ppt_cmd_arbiter.sv
// Round-robin arbiter for four command requesters; each granted event becomes a
// two-byte frame (header, sequence number) on a valid/ready byte stream.
module ppt_cmd_arbiter #(
  parameter int unsigned GAP_CYCLES = 4,
  parameter logic [7:0]  HDR_BASE   = 8'hA0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [3:0] req,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic [3:0] grant,
  output logic       busy,
  output logic [3:0] drop,
  output logic [7:0] seq
);

  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    SEQ  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    req_q;
  logic [3:0]    pend, pend_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic          tx_valid_nxt;
  logic [7:0]    tx_data_nxt;
  logic [3:0]    grant_nxt;
  logic          busy_nxt;
  logic [3:0]    drop_nxt;
  logic [7:0]    seq_nxt;

  logic [3:0]    rise;
  logic [3:0]    clr;
  logic [1:0]    ptr_inc;
  logic [7:0]    pend_dbl;
  logic [3:0]    rot;
  logic [1:0]    off;
  logic [1:0]    win;
  logic [3:0]    win_oh;

  assign rise = req & ~req_q;

  // Rotate pending flags so the search starts just after the last winner.
  always_comb begin
    ptr_inc  = ptr + 2'd1;
    pend_dbl = {pend, pend};
    rot      = 4'(pend_dbl >> ptr_inc);
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else             off = 2'd3;
    win    = ptr_inc + off;
    win_oh = 4'(4'b0001 << win);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_q    <= '0;
      pend     <= '0;
      ptr      <= 2'd3;
      gap_cnt  <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      drop     <= '0;
      seq      <= '0;
    end else begin
      state    <= state_nxt;
      req_q    <= req;
      pend     <= pend_nxt;
      ptr      <= ptr_nxt;
      gap_cnt  <= gap_nxt;
      tx_valid <= tx_valid_nxt;
      tx_data  <= tx_data_nxt;
      grant    <= grant_nxt;
      busy     <= busy_nxt;
      drop     <= drop_nxt;
      seq      <= seq_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    gap_nxt      = gap_cnt;
    tx_valid_nxt = tx_valid;
    tx_data_nxt  = tx_data;
    grant_nxt    = grant;
    seq_nxt      = seq;
    clr          = '0;

    unique case (state)
      IDLE: begin
        if (ena && (pend != 4'd0)) begin
          clr          = win_oh;
          ptr_nxt      = win;
          grant_nxt    = win_oh;
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = HDR_BASE | {6'd0, win};
          state_nxt    = HDR;
        end
      end
      HDR: begin
        if (tx_ready) begin
          tx_data_nxt = seq;
          state_nxt   = SEQ;
        end
      end
      SEQ: begin
        if (tx_ready) begin
          seq_nxt      = seq + 8'd1;
          grant_nxt    = '0;
          tx_valid_nxt = 1'b0;
          tx_data_nxt  = '0;
          if (GAP_CYCLES > 0) begin
            gap_nxt   = GAP_LOAD;
            state_nxt = GAP;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
        else               gap_nxt   = gap_cnt - GW'(1);
      end
    endcase

    // A new edge beats a same-cycle grant clear, so it is never reported as dropped.
    pend_nxt = (pend & ~clr) | rise;
    drop_nxt = rise & pend & ~clr;
    busy_nxt = (state_nxt != IDLE);
  end

endmodule
